// File: rtl/uart_boot_ctrl.sv
// Boot loader sequencer: writes UART-delivered program words into instruction
// memory, tracks count/checksum/errors, and releases the CPU core once loaded.
module uart_boot_ctrl #(
  parameter int unsigned IMEM_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          start,
  input  logic                          prog_en,
  input  logic [31:0]                   prog_addr,
  input  logic [31:0]                   prog_data,
  output logic                          imem_we,
  output logic [$clog2(IMEM_WORDS)-1:0] imem_addr,
  output logic [31:0]                   imem_wdata,
  output logic                          cpu_rst,
  output logic                          load_active,
  output logic [15:0]                   word_count,
  output logic [31:0]                   checksum,
  output logic                          err_range,
  output logic                          err_align
);

  localparam int          AW        = $clog2(IMEM_WORDS);
  localparam logic [32:0] MEM_BYTES = 33'(IMEM_WORDS) << 2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_RUN   = 2'd3;

  logic [1:0]  state;
  logic [31:0] offset;
  logic        aligned, in_range, accept, restart, word_ok, err_nxt;
  logic [15:0] cnt_base, cnt_nxt;
  logic [31:0] sum_base, sum_nxt;
  logic        ea_base, er_base, ea_nxt, er_nxt;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Word qualification; a restart clears the running totals before this word lands
  always_comb begin
    offset   = prog_addr - BASE_ADDR;
    aligned  = (prog_addr[1:0] == 2'b00);
    in_range = (prog_addr >= BASE_ADDR) && ({1'b0, offset} < MEM_BYTES);
    accept   = prog_en && (state != S_DRAIN);
    restart  = prog_en && ((state == S_IDLE) || (state == S_RUN));
    word_ok  = accept && aligned && in_range;

    cnt_base = restart ? 16'd0 : word_count;
    sum_base = restart ? 32'd0 : checksum;
    ea_base  = restart ? 1'b0  : err_align;
    er_base  = restart ? 1'b0  : err_range;

    cnt_nxt  = word_ok ? sat_inc(cnt_base) : cnt_base;
    sum_nxt  = word_ok ? (sum_base + prog_data) : sum_base;
    ea_nxt   = ea_base | (accept && !aligned);
    er_nxt   = er_base | (accept && aligned && !in_range);
    err_nxt  = ea_nxt | er_nxt;
  end

  assign load_active = (state == S_LOAD) || (state == S_DRAIN);

  always_ff @(posedge clk) begin
    if (rstn) begin
      state      <= S_IDLE;
      cpu_rst    <= 1'b1;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      word_count <= '0;
      checksum   <= '0;
      err_range  <= 1'b0;
      err_align  <= 1'b0;
    end else begin
      imem_we <= word_ok;
      if (word_ok) begin
        imem_addr  <= offset[AW+1:2];
        imem_wdata <= prog_data;
      end
      word_count <= cnt_nxt;
      checksum   <= sum_nxt;
      err_align  <= ea_nxt;
      err_range  <= er_nxt;

      // start is judged against flags that already include this cycle's word
      case (state)
        S_IDLE, S_LOAD: begin
          cpu_rst <= 1'b1;
          if (start)        state <= err_nxt ? S_IDLE : S_DRAIN;
          else if (restart) state <= S_LOAD;
        end
        S_DRAIN: begin
          state   <= S_RUN;
          cpu_rst <= 1'b0;
        end
        default: begin
          if (restart) begin
            state   <= S_LOAD;
            cpu_rst <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_boot_ctrl.sv
// Cycle-vector bench for uart_boot_ctrl with a write scoreboard.
module tb_uart_boot_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        start = 1'b0;
  logic        prog_en = 1'b0;
  logic [31:0] prog_addr = '0;
  logic [31:0] prog_data = '0;
  logic        imem_we;
  logic [11:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_rst, load_active, err_range, err_align;
  logic [15:0] word_count;
  logic [31:0] checksum;

  uart_boot_ctrl #(.IMEM_WORDS(4096), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .rstn(rstn), .start(start), .prog_en(prog_en),
    .prog_addr(prog_addr), .prog_data(prog_data),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_rst(cpu_rst), .load_active(load_active), .word_count(word_count),
    .checksum(checksum), .err_range(err_range), .err_align(err_align)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        st;
    logic [31:0] addr;
    logic [31:0] data;
    logic        we;
    logic [15:0] cnt;
    logic [31:0] sum;
    logic        ea;
    logic        er;
    logic        crst;
    logic        la;
  } row_t;

  typedef struct {
    logic [11:0] addr;
    logic [31:0] data;
  } wr_t;

  row_t rows[$];
  wr_t  sb[$];
  int   n_checks = 0;
  int   n_pass = 0;

  task automatic add(input logic en, input logic st, input logic [31:0] addr,
                     input logic [31:0] data, input logic we, input logic [15:0] cnt,
                     input logic [31:0] sum, input logic ea, input logic er,
                     input logic crst, input logic la);
    row_t r;
    r.en = en; r.st = st; r.addr = addr; r.data = data; r.we = we; r.cnt = cnt;
    r.sum = sum; r.ea = ea; r.er = er; r.crst = crst; r.la = la;
    rows.push_back(r);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic expect_write(input logic [31:0] addr, input logic [31:0] data);
    wr_t w;
    w.addr = addr[13:2];
    w.data = data;
    sb.push_back(w);
  endtask

  // Advance one clock; outputs are sampled on the falling edge
  task automatic cyc();
    wr_t w;
    @(negedge clk);
    if (imem_we) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_write: addr %h data %h with nothing expected", imem_addr, imem_wdata);
      end else begin
        w = sb.pop_front();
        chk("wr_addr", {20'd0, imem_addr}, {20'd0, w.addr});
        chk("wr_data", imem_wdata, w.data);
      end
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cpu_rst"}, {31'd0, cpu_rst}, 32'd1);
    chk({tag, "_we"}, {31'd0, imem_we}, 32'd0);
    chk({tag, "_addr"}, {20'd0, imem_addr}, 32'd0);
    chk({tag, "_wdata"}, imem_wdata, 32'd0);
    chk({tag, "_load_active"}, {31'd0, load_active}, 32'd0);
    chk({tag, "_count"}, {16'd0, word_count}, 32'd0);
    chk({tag, "_checksum"}, checksum, 32'd0);
    chk({tag, "_err_range"}, {31'd0, err_range}, 32'd0);
    chk({tag, "_err_align"}, {31'd0, err_align}, 32'd0);
  endtask

  initial begin
    //   en st addr          data          we cnt sum           ea er crst la
    add(1, 0, 32'h0,        32'h11,       1, 1, 32'h11,       0, 0, 1, 1);
    add(0, 0, 32'h0,        32'h0,        0, 1, 32'h11,       0, 0, 1, 1);
    add(1, 0, 32'h4,        32'h22,       1, 2, 32'h33,       0, 0, 1, 1);
    add(1, 0, 32'h8,        32'h33,       1, 3, 32'h66,       0, 0, 1, 1);
    add(0, 1, 32'h0,        32'h0,        0, 3, 32'h66,       0, 0, 1, 1);
    add(0, 0, 32'h0,        32'h0,        0, 3, 32'h66,       0, 0, 0, 0);
    add(0, 0, 32'h0,        32'h0,        0, 3, 32'h66,       0, 0, 0, 0);
    add(0, 1, 32'h0,        32'h0,        0, 3, 32'h66,       0, 0, 0, 0);
    add(1, 0, 32'h10,       32'h7,        1, 1, 32'h7,        0, 0, 1, 1);
    add(1, 0, 32'h6,        32'h99,       0, 1, 32'h7,        1, 0, 1, 1);
    add(1, 0, 32'h4000,     32'h55,       0, 1, 32'h7,        1, 1, 1, 1);
    add(0, 1, 32'h0,        32'h0,        0, 1, 32'h7,        1, 1, 1, 0);
    add(0, 0, 32'h0,        32'h0,        0, 1, 32'h7,        1, 1, 1, 0);
    add(1, 0, 32'h4000,     32'h1,        0, 0, 32'h0,        0, 1, 1, 1);
    add(0, 1, 32'h0,        32'h0,        0, 0, 32'h0,        0, 1, 1, 0);
    add(0, 0, 32'h0,        32'h0,        0, 0, 32'h0,        0, 1, 1, 0);
    add(1, 0, 32'h8,        32'h2,        1, 1, 32'h2,        0, 0, 1, 1);
    add(1, 1, 32'h0,        32'hFFFF_FFFF,1, 2, 32'h1,        0, 0, 1, 1);
    add(0, 0, 32'h0,        32'h0,        0, 2, 32'h1,        0, 0, 0, 0);
    add(1, 0, 32'h0,        32'hA,        1, 1, 32'hA,        0, 0, 1, 1);
    add(0, 1, 32'h0,        32'h0,        0, 1, 32'hA,        0, 0, 1, 1);
    add(1, 0, 32'h4,        32'hB,        0, 1, 32'hA,        0, 0, 0, 0);
    add(1, 0, 32'h0,        32'h5,        1, 1, 32'h5,        0, 0, 1, 1);
    add(1, 0, 32'h0,        32'h6,        1, 2, 32'hB,        0, 0, 1, 1);
    add(1, 0, 32'h3FFC,     32'h1,        1, 3, 32'hC,        0, 0, 1, 1);
    add(0, 0, 32'h0,        32'h0,        0, 3, 32'hC,        0, 0, 1, 1);

    // Reset held for two edges
    cyc();
    cyc();
    chk_reset_vals("reset");
    rstn = 1'b0;

    foreach (rows[i]) begin
      prog_en   = rows[i].en;
      start     = rows[i].st;
      prog_addr = rows[i].addr;
      prog_data = rows[i].data;
      if (rows[i].we) expect_write(rows[i].addr, rows[i].data);
      cyc();
      chk($sformatf("r%0d_we", i), {31'd0, imem_we}, {31'd0, rows[i].we});
      chk($sformatf("r%0d_count", i), {16'd0, word_count}, {16'd0, rows[i].cnt});
      chk($sformatf("r%0d_checksum", i), checksum, rows[i].sum);
      chk($sformatf("r%0d_err_align", i), {31'd0, err_align}, {31'd0, rows[i].ea});
      chk($sformatf("r%0d_err_range", i), {31'd0, err_range}, {31'd0, rows[i].er});
      chk($sformatf("r%0d_cpu_rst", i), {31'd0, cpu_rst}, {31'd0, rows[i].crst});
      chk($sformatf("r%0d_load_active", i), {31'd0, load_active}, {31'd0, rows[i].la});
    end

    // Reset asserted the cycle after a word is accepted mid-load
    prog_en = 1'b1; start = 1'b0; prog_addr = 32'h20; prog_data = 32'h77;
    expect_write(32'h20, 32'h77);
    cyc();
    chk("midload_we", {31'd0, imem_we}, 32'd1);
    chk("midload_count", {16'd0, word_count}, 32'd4);
    rstn = 1'b1; prog_addr = 32'h24; prog_data = 32'h88;
    cyc();
    chk_reset_vals("midload_rst");
    rstn = 1'b0; prog_en = 1'b0;
    cyc();
    chk("post_rst_we", {31'd0, imem_we}, 32'd0);
    chk("post_rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);

    // start from a clean IDLE goes through DRAIN into RUN
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("idle_start_drain_la", {31'd0, load_active}, 32'd1);
    chk("idle_start_drain_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    cyc();
    chk("idle_start_run_cpu_rst", {31'd0, cpu_rst}, 32'd0);
    chk("idle_start_run_la", {31'd0, load_active}, 32'd0);

    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_boot_ctrl.md
UART_BOOT_CTRL -- requirements
Module: uart_boot_ctrl

Interface
REQ-001 SHALL have parameter IMEM_WORDS, default 4096, instruction memory depth in 32-bit words (power of two).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of instruction memory word 0.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rstn  input  1  synchronous active-high reset (1 = reset).
REQ-005 SHALL have port start  input  1  one-cycle pulse from the UART controller to launch the program.
REQ-006 SHALL have port prog_en  input  1  one-cycle pulse; prog_addr/prog_data are valid.
REQ-007 SHALL have port prog_addr  input  32  byte address of the program word.
REQ-008 SHALL have port prog_data  input  32  program word.
REQ-009 SHALL have port imem_we  output  1  instruction memory write strobe.
REQ-010 SHALL have port imem_addr  output  $clog2(IMEM_WORDS)  word address.
REQ-011 SHALL have port imem_wdata  output  32  write data.
REQ-012 SHALL have port cpu_rst  output  1  holds the CPU core in reset when 1.
REQ-013 SHALL have port load_active  output  1  1 while in LOAD or DRAIN.
REQ-014 SHALL have port word_count  output  16  words written in the current load.
REQ-015 SHALL have port checksum  output  32  sum of written words, modulo 2^32.
REQ-016 SHALL have port err_range  output  1  sticky flag: an address fell outside memory.
REQ-017 SHALL have port err_align  output  1  sticky flag: prog_addr[1:0] != 0.

Function
REQ-018 SHALL implement the states IDLE, LOAD, DRAIN and RUN.
REQ-019 SHALL, on prog_en in IDLE or RUN, enter LOAD next cycle, with these actions in the same edge:
- cpu_rst = 1
- word_count = 0, checksum = 0, both error flags = 0
- the word presented with that prog_en is processed as a LOAD word.
REQ-020 SHALL treat a word as valid when prog_addr[1:0] == 0 and BASE_ADDR <= prog_addr < BASE_ADDR + 4*IMEM_WORDS.
REQ-021 SHALL, for a valid word, assert imem_we for exactly one cycle, one cycle after prog_en (latency 1), with:
- imem_addr = (prog_addr - BASE_ADDR) >> 2
- imem_wdata = prog_data.
REQ-022 SHALL, for each valid word:
- increment word_count, saturating at 16'hFFFF
- add prog_data to checksum (32-bit wrap).
REQ-023 SHALL, for a misaligned word, issue no write, set err_align and leave count and checksum unchanged.
REQ-024 SHALL, for an aligned out-of-range word, issue no write, set err_range and leave count and checksum unchanged.
REQ-025 SHALL, on start in LOAD or IDLE with no error flag set, go to DRAIN next cycle, then to RUN the following cycle.
REQ-026 SHALL drive cpu_rst = 0 from the first cycle in RUN, i.e. 2 cycles after start is sampled, so any pending write has completed.
REQ-027 SHALL, on start in LOAD with any error flag set, go to IDLE with cpu_rst = 1, retaining the error flags.
REQ-028 SHALL, when prog_en and start coincide, process the word per REQ-021..024 first; start is then evaluated against the updated error flags.
REQ-029 SHALL ignore prog_en while in DRAIN: no write and no flag change.
REQ-030 SHALL ignore start while in DRAIN or RUN.
REQ-031 SHALL keep imem_we at 0 in every cycle not covered by REQ-021.
REQ-032 SHALL hold imem_addr and imem_wdata at their last written values when imem_we = 0.
REQ-033 SHALL make a repeated write to the same address overwrite memory, and count and sum it again.

Reset
REQ-034 SHALL, while rstn = 1 at a clock edge, set the state to IDLE and drive:
- cpu_rst = 1
- imem_we = 0, imem_addr = 0, imem_wdata = 0
- load_active = 0
- word_count = 0, checksum = 0
- err_range = 0, err_align = 0.
REQ-035 SHALL, on reset in any state (including mid-LOAD or DRAIN), abort with no further write; a write strobe already registered SHALL be cleared.

Verification
REQ-036 SHALL cover a normal load:
- stimulus: prog_en at addrs 0x0, 0x4, 0x8 with data 0x11, 0x22, 0x33, then start
- response: writes to imem_addr 0, 1, 2; word_count = 3; checksum = 0x66; cpu_rst falls 2 cycles after start.
REQ-037 SHALL cover a range error:
- stimulus: prog_en at addr 0x4000 (IMEM_WORDS = 4096), then start
- response: no imem_we; err_range = 1; state IDLE; cpu_rst stays 1.
REQ-038 SHALL cover an alignment error:
- stimulus: prog_en at addr 0x6
- response: no write; err_align = 1; word_count unchanged.
REQ-039 SHALL cover coincident events:
- stimulus: prog_en (addr 0x0, data 0xFFFF_FFFF) and start in the same cycle, after one prior word of 0x2
- response: write issued; checksum = 0x1; RUN reached.
REQ-040 SHALL cover a reload from RUN:
- stimulus: prog_en in RUN
- response: cpu_rst = 1 next cycle; word_count = 1; flags cleared.
REQ-041 SHALL cover reset mid-load:
- stimulus: rstn = 1 in the cycle after prog_en
- response: imem_we = 0; all outputs at reset values; cpu_rst = 1.
